// File: rtl/pic_bus_pkg.sv
// Shared definitions for the 8259-style PIC host bus: FSM encoding, default
// bus timing and the register-select rules used to address ICW/OCW writes.
package pic_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_RECOVER
  } pic_state_e;

  localparam int unsigned DEF_SETUP_CYCLES   = 1;
  localparam int unsigned DEF_STROBE_CYCLES  = 2;
  localparam int unsigned DEF_HOLD_CYCLES    = 1;
  localparam int unsigned DEF_RECOVER_CYCLES = 1;

  // A0 and data-bit requirements for each PIC register write.
  localparam logic        A0_ICW1    = 1'b0;
  localparam logic        A0_ICW2_4  = 1'b1;
  localparam logic        A0_OCW1    = 1'b1;
  localparam logic        A0_OCW2    = 1'b0;
  localparam logic        A0_OCW3    = 1'b0;
  localparam int unsigned ICW1_BIT   = 4;
  localparam int unsigned OCW3_BIT   = 3;

  typedef enum logic [1:0] {
    REG_ICW1,
    REG_ICW2_4_OCW1,
    REG_OCW2,
    REG_OCW3
  } pic_reg_e;

  function automatic pic_reg_e decode_reg(input logic a0, input logic [7:0] d);
    if (a0 == A0_ICW2_4)  return REG_ICW2_4_OCW1;
    if (d[ICW1_BIT])      return REG_ICW1;
    if (d[OCW3_BIT])      return REG_OCW3;
    return REG_OCW2;
  endfunction

  // A phase of N cycles loads N-1 so the counter reaches zero in its last cycle.
  function automatic logic [3:0] phase_load(input int unsigned cycles);
    return (cycles == 0) ? 4'd0 : 4'(cycles - 1);
  endfunction

endpackage

// File: rtl/pic_phase_timer.sv
// Loadable 4-bit down-counter that flags the last cycle of a bus phase.
module pic_phase_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_value,
  output logic       done
);

  logic [3:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - 4'd1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/pic_host_bus_master.sv
// Host-side initiator turning single-beat requests into timed 8259 bus cycles
// (CS_n/RD_n/WR_n/A0/data) with read data returned on a response pulse.
module pic_host_bus_master
  import pic_bus_pkg::*;
#(
  parameter int unsigned SETUP_CYCLES   = DEF_SETUP_CYCLES,
  parameter int unsigned STROBE_CYCLES  = DEF_STROBE_CYCLES,
  parameter int unsigned HOLD_CYCLES    = DEF_HOLD_CYCLES,
  parameter int unsigned RECOVER_CYCLES = DEF_RECOVER_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic       req_a0,
  input  logic [7:0] req_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       CS_n,
  output logic       RD_n,
  output logic       WR_n,
  output logic       A0,
  output logic [7:0] data_out,
  output logic       data_oe,
  input  logic [7:0] data_in
);

  pic_state_e state;
  pic_state_e state_nxt;

  logic       cur_write;
  logic       cur_a0;
  logic [7:0] cur_data;

  logic       accept;
  logic       capture;
  logic       nxt_write;
  logic       nxt_a0;
  logic [7:0] nxt_data;
  logic       bus_active;

  logic       timer_load;
  logic [3:0] timer_value;
  logic       phase_done;

  // Zero-length phases fall through to the next phase that has cycles.
  function automatic pic_state_e next_live(input pic_state_e s);
    pic_state_e t;
    t = s;
    if (t == ST_SETUP && SETUP_CYCLES == 0)     t = ST_STROBE;
    if (t == ST_HOLD && HOLD_CYCLES == 0)       t = ST_RECOVER;
    if (t == ST_RECOVER && RECOVER_CYCLES == 0) t = ST_IDLE;
    return t;
  endfunction

  function automatic logic [3:0] load_for(input pic_state_e s);
    case (s)
      ST_SETUP:   return phase_load(SETUP_CYCLES);
      ST_STROBE:  return phase_load(STROBE_CYCLES);
      ST_HOLD:    return phase_load(HOLD_CYCLES);
      ST_RECOVER: return phase_load(RECOVER_CYCLES);
      default:    return '0;
    endcase
  endfunction

  pic_phase_timer u_phase_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (timer_load),
    .load_value (timer_value),
    .done       (phase_done)
  );

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    capture   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          accept    = 1'b1;
          state_nxt = next_live(ST_SETUP);
        end
      end
      ST_SETUP: begin
        if (phase_done) state_nxt = ST_STROBE;
      end
      ST_STROBE: begin
        if (phase_done) begin
          capture   = !cur_write;
          state_nxt = next_live(ST_HOLD);
        end
      end
      ST_HOLD: begin
        if (phase_done) state_nxt = next_live(ST_RECOVER);
      end
      ST_RECOVER: begin
        if (phase_done) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase

    timer_load  = (state_nxt != state);
    timer_value = load_for(state_nxt);

    // Pins are registered from the next state, so the accepted request must
    // be visible in the same edge that latches it.
    nxt_write  = accept ? req_write : cur_write;
    nxt_a0     = accept ? req_a0    : cur_a0;
    nxt_data   = accept ? req_data  : cur_data;
    bus_active = (state_nxt == ST_SETUP) || (state_nxt == ST_STROBE) ||
                 (state_nxt == ST_HOLD);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      cur_write <= 1'b0;
      cur_a0    <= 1'b0;
      cur_data  <= '0;
      CS_n      <= 1'b1;
      RD_n      <= 1'b1;
      WR_n      <= 1'b1;
      A0        <= 1'b0;
      data_out  <= '0;
      data_oe   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      req_ready <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cur_write <= req_write;
        cur_a0    <= req_a0;
        cur_data  <= req_data;
      end

      CS_n <= !bus_active;
      RD_n <= !((state_nxt == ST_STROBE) && !nxt_write);
      WR_n <= !((state_nxt == ST_STROBE) && nxt_write);

      if (bus_active) A0 <= nxt_a0;
      data_oe <= bus_active && nxt_write;
      if (bus_active && nxt_write) data_out <= nxt_data;

      rsp_valid <= capture;
      if (capture) rsp_data <= data_in;

      req_ready <= (state_nxt == ST_IDLE);
    end
  end

endmodule

// File: tb/tb_pic_host_bus_master.sv
// Directed bench for pic_host_bus_master: default timing instance plus a
// minimum-timing instance, with a small PIC bus-buffer write decoder.
module tb_pic_host_bus_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Default-timing DUT
  logic       reset, req_valid, req_write, req_a0;
  logic [7:0] req_data, data_in;
  logic       req_ready, rsp_valid, CS_n, RD_n, WR_n, A0, data_oe;
  logic [7:0] rsp_data, data_out;

  // Minimum-timing DUT
  logic       m_reset, m_req_valid, m_req_write, m_req_a0;
  logic [7:0] m_req_data, m_data_in;
  logic       m_req_ready, m_rsp_valid, m_CS_n, m_RD_n, m_WR_n, m_A0, m_data_oe;
  logic [7:0] m_rsp_data, m_data_out;

  pic_host_bus_master dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_a0(req_a0), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .CS_n(CS_n), .RD_n(RD_n),
    .WR_n(WR_n), .A0(A0), .data_out(data_out), .data_oe(data_oe),
    .data_in(data_in)
  );

  pic_host_bus_master #(
    .SETUP_CYCLES(0), .STROBE_CYCLES(1), .HOLD_CYCLES(0), .RECOVER_CYCLES(0)
  ) dut_min (
    .clk(clk), .reset(m_reset), .req_valid(m_req_valid), .req_ready(m_req_ready),
    .req_write(m_req_write), .req_a0(m_req_a0), .req_data(m_req_data),
    .rsp_valid(m_rsp_valid), .rsp_data(m_rsp_data), .CS_n(m_CS_n), .RD_n(m_RD_n),
    .WR_n(m_WR_n), .A0(m_A0), .data_out(m_data_out), .data_oe(m_data_oe),
    .data_in(m_data_in)
  );

  // PIC bus-buffer model: kinds 1=ICW1, 2=ICW2-4/OCW1, 3=OCW2, 4=OCW3.
  int log_kind[32];
  int log_n = 0;
  always @(posedge WR_n) begin
    if (!CS_n && !reset && log_n < 32) begin
      if (A0)               log_kind[log_n] = 2;
      else if (data_out[4]) log_kind[log_n] = 1;
      else if (data_out[3]) log_kind[log_n] = 4;
      else                  log_kind[log_n] = 3;
      log_n++;
    end
  end

  // Bus protocol violations: both strobes low, or a strobe low without CS_n.
  int viol_cnt = 0;
  always @(posedge clk) begin
    #1;
    if (!RD_n && !WR_n) viol_cnt++;
    if ((!RD_n || !WR_n) && CS_n) viol_cnt++;
    if (!m_RD_n && !m_WR_n) viol_cnt++;
    if ((!m_RD_n || !m_WR_n) && m_CS_n) viol_cnt++;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (req_ready) begin ok = 1'b1; return; end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; m_reset = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    checks++; if (CS_n !== 1'b1) begin errors++; $display("FAIL rst_cs_n: got %b want 1", CS_n); end
    checks++; if (RD_n !== 1'b1) begin errors++; $display("FAIL rst_rd_n: got %b want 1", RD_n); end
    checks++; if (WR_n !== 1'b1) begin errors++; $display("FAIL rst_wr_n: got %b want 1", WR_n); end
    checks++; if (A0 !== 1'b0) begin errors++; $display("FAIL rst_a0: got %b want 0", A0); end
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL rst_data_out: got %h want 00", data_out); end
    checks++; if (data_oe !== 1'b0) begin errors++; $display("FAIL rst_data_oe: got %b want 0", data_oe); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
    checks++; if (rsp_data !== 8'h00) begin errors++; $display("FAIL rst_rsp_data: got %h want 00", rsp_data); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready: got %b want 0", req_ready); end
    checks++; if (m_CS_n !== 1'b1) begin errors++; $display("FAIL rst_m_cs_n: got %b want 1", m_CS_n); end
    checks++; if (m_req_ready !== 1'b0) begin errors++; $display("FAIL rst_m_req_ready: got %b want 0", m_req_ready); end
    reset = 1'b0; m_reset = 1'b0;
    @(posedge clk); #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b want 1", req_ready); end
    checks++; if (m_req_ready !== 1'b1) begin errors++; $display("FAIL rst_release_m_ready: got %b want 1", m_req_ready); end
  endtask

  task automatic test_write_icw1();
    bit ok;
    int base;
    logic exp_cs, exp_wr, exp_oe, exp_rdy;
    wait_ready(ok);
    checks++; if (!ok) begin errors++; $display("FAIL icw1_ready: got req_ready=0 want 1"); end
    base = log_n;
    req_write = 1'b1; req_a0 = 1'b0; req_data = 8'h13; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      exp_cs  = !(k <= 4);
      exp_wr  = !(k == 2 || k == 3);
      exp_oe  = (k <= 4);
      exp_rdy = (k == 6);
      checks++; if (CS_n !== exp_cs) begin errors++; $display("FAIL icw1_cs_n c%0d: got %b want %b", k, CS_n, exp_cs); end
      checks++; if (WR_n !== exp_wr) begin errors++; $display("FAIL icw1_wr_n c%0d: got %b want %b", k, WR_n, exp_wr); end
      checks++; if (RD_n !== 1'b1) begin errors++; $display("FAIL icw1_rd_n c%0d: got %b want 1", k, RD_n); end
      checks++; if (data_oe !== exp_oe) begin errors++; $display("FAIL icw1_data_oe c%0d: got %b want %b", k, data_oe, exp_oe); end
      checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL icw1_req_ready c%0d: got %b want %b", k, req_ready, exp_rdy); end
      if (k <= 4) begin
        checks++; if (data_out !== 8'h13) begin errors++; $display("FAIL icw1_data_out c%0d: got %h want 13", k, data_out); end
        checks++; if (A0 !== 1'b0) begin errors++; $display("FAIL icw1_a0 c%0d: got %b want 0", k, A0); end
      end
      @(posedge clk); #1;
    end
    checks++; if (log_n - base !== 1) begin errors++; $display("FAIL icw1_pulses: got %0d want 1", log_n - base); end
    if (log_n > base) begin
      checks++; if (log_kind[base] !== 1) begin errors++; $display("FAIL icw1_decode: got kind %0d want 1", log_kind[base]); end
    end
  endtask

  task automatic test_read();
    bit ok;
    logic exp_cs, exp_rd, exp_v;
    wait_ready(ok);
    checks++; if (!ok) begin errors++; $display("FAIL read_ready: got req_ready=0 want 1"); end
    data_in = 8'hA5;
    req_write = 1'b0; req_a0 = 1'b1; req_data = 8'h00; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      exp_cs = !(k <= 4);
      exp_rd = !(k == 2 || k == 3);
      exp_v  = (k == 4);
      checks++; if (CS_n !== exp_cs) begin errors++; $display("FAIL read_cs_n c%0d: got %b want %b", k, CS_n, exp_cs); end
      checks++; if (RD_n !== exp_rd) begin errors++; $display("FAIL read_rd_n c%0d: got %b want %b", k, RD_n, exp_rd); end
      checks++; if (WR_n !== 1'b1) begin errors++; $display("FAIL read_wr_n c%0d: got %b want 1", k, WR_n); end
      checks++; if (data_oe !== 1'b0) begin errors++; $display("FAIL read_data_oe c%0d: got %b want 0", k, data_oe); end
      checks++; if (rsp_valid !== exp_v) begin errors++; $display("FAIL read_rsp_valid c%0d: got %b want %b", k, rsp_valid, exp_v); end
      if (k <= 4) begin
        checks++; if (A0 !== 1'b1) begin errors++; $display("FAIL read_a0 c%0d: got %b want 1", k, A0); end
      end
      if (k >= 4) begin
        checks++; if (rsp_data !== 8'hA5) begin errors++; $display("FAIL read_rsp_data c%0d: got %h want a5", k, rsp_data); end
      end
      if (k == 4) data_in = 8'h5C;
      @(posedge clk); #1;
    end
    checks++; if (rsp_data !== 8'hA5) begin errors++; $display("FAIL read_rsp_hold: got %h want a5", rsp_data); end
  endtask

  task automatic test_init_sequence();
    bit ok, took;
    int base, vbase, idx;
    int acc[4];
    logic [7:0] seq_data[4];
    logic       seq_a0[4];
    seq_data = '{8'h13, 8'h08, 8'h01, 8'hFF};
    seq_a0   = '{1'b0, 1'b1, 1'b1, 1'b1};
    acc      = '{-1, -1, -1, -1};
    wait_ready(ok);
    checks++; if (!ok) begin errors++; $display("FAIL init_ready: got req_ready=0 want 1"); end
    base = log_n; vbase = viol_cnt; idx = 0;
    req_write = 1'b1; req_a0 = seq_a0[0]; req_data = seq_data[0]; req_valid = 1'b1;
    for (int e = 0; e < 40 && idx < 4; e++) begin
      took = req_ready;
      if (took) acc[idx] = e;
      @(posedge clk); #1;
      if (took) begin
        idx++;
        if (idx < 4) begin req_a0 = seq_a0[idx]; req_data = seq_data[idx]; end
        else req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    checks++; if (idx !== 4) begin errors++; $display("FAIL init_accepts: got %0d want 4", idx); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (acc[i] !== 6 * i) begin errors++; $display("FAIL init_accept_edge%0d: got %0d want %0d", i, acc[i], 6 * i); end
    end
    for (int i = 0; i < 6; i++) begin @(posedge clk); #1; end
    checks++; if (log_n - base !== 4) begin errors++; $display("FAIL init_pulses: got %0d want 4", log_n - base); end
    if (log_n - base >= 4) begin
      checks++; if (log_kind[base] !== 1) begin errors++; $display("FAIL init_kind0: got %0d want 1", log_kind[base]); end
      for (int i = 1; i < 4; i++) begin
        checks++; if (log_kind[base + i] !== 2) begin errors++; $display("FAIL init_kind%0d: got %0d want 2", i, log_kind[base + i]); end
      end
    end
    checks++; if (viol_cnt !== vbase) begin errors++; $display("FAIL init_strobe_overlap: got %0d violations want 0", viol_cnt - vbase); end
  endtask

  task automatic test_min_timing();
    int vbase;
    vbase = viol_cnt;
    m_req_write = 1'b1; m_req_a0 = 1'b1; m_req_data = 8'h5A; m_req_valid = 1'b1;
    @(posedge clk); #1;
    m_req_valid = 1'b0;
    checks++; if (m_WR_n !== 1'b0) begin errors++; $display("FAIL min_wr_c1: got %b want 0", m_WR_n); end
    checks++; if (m_CS_n !== 1'b0) begin errors++; $display("FAIL min_cs_c1: got %b want 0", m_CS_n); end
    checks++; if (m_req_ready !== 1'b0) begin errors++; $display("FAIL min_ready_c1: got %b want 0", m_req_ready); end
    checks++; if (m_data_oe !== 1'b1) begin errors++; $display("FAIL min_oe_c1: got %b want 1", m_data_oe); end
    checks++; if (m_data_out !== 8'h5A) begin errors++; $display("FAIL min_data_c1: got %h want 5a", m_data_out); end
    @(posedge clk); #1;
    checks++; if (m_WR_n !== 1'b1) begin errors++; $display("FAIL min_wr_c2: got %b want 1", m_WR_n); end
    checks++; if (m_CS_n !== 1'b1) begin errors++; $display("FAIL min_cs_c2: got %b want 1", m_CS_n); end
    checks++; if (m_req_ready !== 1'b1) begin errors++; $display("FAIL min_ready_c2: got %b want 1", m_req_ready); end
    checks++; if (m_data_oe !== 1'b0) begin errors++; $display("FAIL min_oe_c2: got %b want 0", m_data_oe); end
    checks++; if (m_A0 !== 1'b1) begin errors++; $display("FAIL min_a0_hold: got %b want 1", m_A0); end
    m_data_in = 8'h3C;
    m_req_write = 1'b0; m_req_a0 = 1'b0; m_req_valid = 1'b1;
    @(posedge clk); #1;
    m_req_valid = 1'b0;
    checks++; if (m_RD_n !== 1'b0) begin errors++; $display("FAIL min_rd_c1: got %b want 0", m_RD_n); end
    checks++; if (m_rsp_valid !== 1'b0) begin errors++; $display("FAIL min_rsp_c1: got %b want 0", m_rsp_valid); end
    @(posedge clk); #1;
    checks++; if (m_RD_n !== 1'b1) begin errors++; $display("FAIL min_rd_c2: got %b want 1", m_RD_n); end
    checks++; if (m_rsp_valid !== 1'b1) begin errors++; $display("FAIL min_rsp_c2: got %b want 1", m_rsp_valid); end
    checks++; if (m_rsp_data !== 8'h3C) begin errors++; $display("FAIL min_rsp_data: got %h want 3c", m_rsp_data); end
    checks++; if (m_req_ready !== 1'b1) begin errors++; $display("FAIL min_ready_rd: got %b want 1", m_req_ready); end
    @(posedge clk); #1;
    checks++; if (m_rsp_valid !== 1'b0) begin errors++; $display("FAIL min_rsp_c3: got %b want 0", m_rsp_valid); end
    checks++; if (viol_cnt !== vbase) begin errors++; $display("FAIL min_strobe_overlap: got %0d violations want 0", viol_cnt - vbase); end
  endtask

  task automatic test_reset_during_write();
    bit ok;
    wait_ready(ok);
    checks++; if (!ok) begin errors++; $display("FAIL rstw_ready: got req_ready=0 want 1"); end
    req_write = 1'b1; req_a0 = 1'b1; req_data = 8'h08; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (WR_n !== 1'b0) begin errors++; $display("FAIL rstw_strobe2: got %b want 0", WR_n); end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (CS_n !== 1'b1) begin errors++; $display("FAIL rstw_cs_n: got %b want 1", CS_n); end
    checks++; if (WR_n !== 1'b1) begin errors++; $display("FAIL rstw_wr_n: got %b want 1", WR_n); end
    checks++; if (RD_n !== 1'b1) begin errors++; $display("FAIL rstw_rd_n: got %b want 1", RD_n); end
    checks++; if (data_oe !== 1'b0) begin errors++; $display("FAIL rstw_data_oe: got %b want 0", data_oe); end
    checks++; if (A0 !== 1'b0) begin errors++; $display("FAIL rstw_a0: got %b want 0", A0); end
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL rstw_data_out: got %h want 00", data_out); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rstw_ready_in_reset: got %b want 0", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rstw_rsp_valid: got %b want 0", rsp_valid); end
    reset = 1'b0;
    @(posedge clk); #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rstw_ready_after: got %b want 1", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rstw_rsp_after: got %b want 0", rsp_valid); end
  endtask

  task automatic test_reset_during_read();
    bit ok;
    int vcount;
    wait_ready(ok);
    checks++; if (!ok) begin errors++; $display("FAIL rstr_ready: got req_ready=0 want 1"); end
    data_in = 8'h77;
    req_write = 1'b0; req_a0 = 1'b1; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++; if (CS_n !== 1'b0 || RD_n !== 1'b1) begin errors++; $display("FAIL rstr_setup: got cs_n=%b rd_n=%b want 0/1", CS_n, RD_n); end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    vcount = 0;
    for (int k = 0; k < 8; k++) begin
      if (rsp_valid) vcount++;
      checks++; if (rsp_data !== 8'h00) begin errors++; $display("FAIL rstr_rsp_data c%0d: got %h want 00", k, rsp_data); end
      @(posedge clk); #1;
    end
    checks++; if (vcount !== 0) begin errors++; $display("FAIL rstr_rsp_valid: got %0d pulses want 0", vcount); end
    checks++; if (CS_n !== 1'b1) begin errors++; $display("FAIL rstr_cs_idle: got %b want 1", CS_n); end
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_a0 = 1'b0;
    req_data = 8'h00; data_in = 8'h00;
    m_reset = 1'b1; m_req_valid = 1'b0; m_req_write = 1'b0; m_req_a0 = 1'b0;
    m_req_data = 8'h00; m_data_in = 8'h00;
    test_reset();
    test_write_icw1();
    test_read();
    test_init_sequence();
    test_min_timing();
    test_reset_during_write();
    test_reset_during_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pic_host_bus_master.md
# pic_host_bus_master

Host-side bus initiator for the 8259-style PIC register interface. It converts single-beat read/write requests from an internal controller (init sequencer or CPU model) into correctly timed CS_n / RD_n / WR_n / A0 / data cycles. The PIC's bus buffer detects writes on the WR_n rising edge and latches data while WR_n and CS_n are low, so this block keeps address, data and chip select stable across the whole strobe plus a hold phase. On reads it captures the PIC's data lines and returns them on a response channel.

## Interface
- SETUP_CYCLES, 1: cycles CS_n/A0/data are driven before the strobe falls; range 0–15.
- STROBE_CYCLES, 2: cycles RD_n/WR_n are low; range 1–15 (0 illegal).
- HOLD_CYCLES, 1: cycles after the strobe rises with CS_n/A0/data held; range 0–15.
- RECOVER_CYCLES, 1: idle cycles with CS_n high before the next request is accepted; range 0–15.

- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_write  in  1  1 = write, 0 = read.
- req_a0  in  1  register select driven on A0.
- req_data  in  8  write data.
- rsp_valid  out  1  one-cycle pulse: read data valid.
- rsp_data  out  8  captured read data; holds until the next capture.
- CS_n  out  1  chip select, active-low.
- RD_n  out  1  read strobe, active-low.
- WR_n  out  1  write strobe, active-low.
- A0  out  1  address bit.
- data_out  out  8  bus write data.
- data_oe  out  1  drive enable for data_out.
- data_in  in  8  bus data from the PIC.

## Operation
- States: IDLE, SETUP, STROBE, HOLD, RECOVER.
- A single 4-bit phase down-counter is loaded on each state entry with (parameter − 1). A state with a 0 parameter is skipped, so the next non-zero state is entered directly.
- IDLE:
  - req_ready=1.
  - On req_valid & req_ready, latch req_write, req_a0 and req_data, then go to SETUP.
- SETUP:
  - CS_n=0; A0=latched a0.
  - For writes: data_oe=1 and data_out=latched data.
  - RD_n=WR_n=1.
- STROBE:
  - As SETUP, plus WR_n=0 (write) or RD_n=0 (read).
  - For reads, data_in is registered into rsp_data on the rising edge that ends the last STROBE cycle.
- HOLD:
  - Strobes are high. CS_n, A0, data_out and data_oe are unchanged from STROBE.
  - rsp_valid=1 for exactly the first cycle after a read capture. This is the first HOLD cycle, or the first cycle after STROBE when HOLD is skipped.
- RECOVER:
  - CS_n=1, data_oe=0, A0 holds its last value, req_ready=0.
- Only one strobe is ever low at a time. CS_n is low for the entire time either strobe is low.
- No request queueing. req_valid while req_ready=0 is ignored; the source holds the request.
- Reset values: state IDLE, CS_n=RD_n=WR_n=1, A0=0, data_out=0x00, data_oe=0, rsp_valid=0, rsp_data=0x00, req_ready=0 during the reset cycle and 1 after.
- Reset mid-operation:
  - The cycle is abandoned and all outputs take their reset values on the next edge.
  - A read aborted before capture produces no rsp_valid.
  - An aborted write may or may not be seen by the PIC; the controller re-initialises the PIC after reset.

## Timing
- All outputs are registered; no combinational path from req_* to bus pins.
- Defaults, request accepted at edge 0:
  - Cycle 1: SETUP.
  - Cycles 2–3: STROBE.
  - Cycle 4: HOLD (rsp_valid here for reads).
  - Cycle 5: RECOVER.
  - Cycle 6: IDLE with req_ready=1.
- Occupancy = 1 + SETUP + STROBE + HOLD + RECOVER cycles per access, including the IDLE acceptance cycle.
- Back-to-back: CS_n is high for at least max(RECOVER_CYCLES,1) cycles between accesses, because IDLE always deasserts CS_n.

## Structure
- Shared package/include pic_bus_pkg:
  - State encoding.
  - Default timing constants.
  - Register-select constants: ICW1 needs A0=0 and D4=1; ICW2–4 and OCW1 need A0=1; OCW2 needs A0=0, D4=0, D3=0; OCW3 needs A0=0, D4=0, D3=1.
- One sub-module: pic_phase_timer, a loadable 4-bit down-counter with a done flag.

## Test plan
- **Write ICW1:** write 0x13 with A0=0 at default timing.
  - CS_n low cycles 1–4, WR_n low cycles 2–3, data_out=0x13 with data_oe=1 cycles 1–4.
  - PIC bus-buffer model pulses ICW_1 once.
- **Read:** read with A0=1 while data_in=0xA5.
  - RD_n low cycles 2–3, rsp_valid high only in cycle 4, rsp_data=0xA5 after that, data_oe=0 throughout.
- **Init sequence:** req_valid held high for writes 0x13 (A0=0), 0x08, 0x01, 0xFF (A0=1).
  - Accepted at edges 0, 6, 12, 18; never two strobes overlapping.
  - PIC model decodes ICW1 followed by three ICW_2_4/OCW_1 write pulses.
- **Minimum timing:** SETUP=0, STROBE=1, HOLD=0, RECOVER=0.
  - Write has WR_n low for exactly one cycle, CS_n low only that cycle, and req_ready=1 two cycles after acceptance.
- **Reset during write:** reset asserted in the second STROBE cycle.
  - Next cycle CS_n=WR_n=RD_n=1, data_oe=0; no rsp_valid; req_ready=1 the cycle after reset drops.
- **Reset during read:** reset asserted in SETUP of a read.
  - rsp_valid never asserts and rsp_data stays 0x00.
